// File: rtl/algorithm_reduce_if.sv
// Start/result handshake plus element stream for algorithm_reduce.
// The caller uses the master modport; the reducer uses the slave modport.
interface algorithm_reduce_if #(
    parameter int N  = 8,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  sIn;
    logic          sIn_valid;
    logic          sIn_last;
    logic          sIn_ready;
    logic [N-1:0]  sum;
    logic [CW-1:0] count;
    logic          ovf;

    modport master (
        output in_valid, out_ready, sIn, sIn_valid, sIn_last,
        input  in_ready, out_valid, sIn_ready, sum, count, ovf
    );

    modport slave (
        input  in_valid, out_ready, sIn, sIn_valid, sIn_last,
        output in_ready, out_valid, sIn_ready, sum, count, ovf
    );
endinterface

// File: rtl/algorithm_reduce.sv
// Signed stream reducer (sum/min/max) with element count and start/result handshake.
// Define ALGORITHM_REDUCE_SAT_EN to make the sum saturate and report ovf.
module algorithm_reduce #(
    parameter int N  = 8,
    parameter int OP = 0,
    parameter int CW = 16
) (
    input  logic               clk,
    input  logic               nrst,
    algorithm_reduce_if.slave  bus
);

    if (OP < 0 || OP > 2) begin : g_bad_op
        $error("algorithm_reduce: OP must be 0 (sum), 1 (min) or 2 (max)");
    end

    localparam logic [N-1:0] SMAX  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMIN  = {1'b1, {(N-1){1'b0}}};
    // Seed value that leaves the first element unchanged under the chosen operation.
    localparam logic [N-1:0] IDENT = (OP == 1) ? SMAX : ((OP == 2) ? SMIN : '0);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        r_state;
    logic          r_inReady;
    logic          r_sInReady;
    logic          r_outValid;
    logic [N-1:0]  r_acc;
    logic [CW-1:0] r_count;
    logic [N-1:0]  w_next;

`ifdef ALGORITHM_REDUCE_SAT_EN
    logic          r_ovf;
    logic [N:0]    w_wide;
    logic          w_clamp;
`endif

    always_comb begin
        w_next = r_acc;
`ifdef ALGORITHM_REDUCE_SAT_EN
        w_wide  = {r_acc[N-1], r_acc} + {bus.sIn[N-1], bus.sIn};
        w_clamp = 1'b0;
`endif
        case (OP)
            1: w_next = ($signed(bus.sIn) < $signed(r_acc)) ? bus.sIn : r_acc;
            2: w_next = ($signed(bus.sIn) > $signed(r_acc)) ? bus.sIn : r_acc;
            default: begin
`ifdef ALGORITHM_REDUCE_SAT_EN
                // Differing top two bits of the widened sum mean it left the N-bit range.
                if (w_wide[N] != w_wide[N-1]) begin
                    w_clamp = 1'b1;
                    w_next  = w_wide[N] ? SMIN : SMAX;
                end else begin
                    w_next  = w_wide[N-1:0];
                end
`else
                w_next = r_acc + bus.sIn;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_inReady  <= 1'b1;
            r_sInReady <= 1'b0;
            r_outValid <= 1'b0;
            r_acc      <= '0;
            r_count    <= '0;
`ifdef ALGORITHM_REDUCE_SAT_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state    <= ACCUM;
                        r_inReady  <= 1'b0;
                        r_sInReady <= 1'b1;
                        r_acc      <= IDENT;
                        r_count    <= '0;
`ifdef ALGORITHM_REDUCE_SAT_EN
                        r_ovf      <= 1'b0;
`endif
                    end
                end
                ACCUM: begin
                    if (bus.sIn_valid) begin
                        r_acc <= w_next;
                        if (r_count != {CW{1'b1}}) begin
                            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                        end
`ifdef ALGORITHM_REDUCE_SAT_EN
                        if (w_clamp) begin
                            r_ovf <= 1'b1;
                        end
`endif
                        if (bus.sIn_last) begin
                            r_state    <= DONE;
                            r_sInReady <= 1'b0;
                            r_outValid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_inReady  <= 1'b1;
                    r_sInReady <= 1'b0;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.sIn_ready = r_sInReady;
    assign bus.out_valid = r_outValid;
    assign bus.sum       = r_acc;
    assign bus.count     = r_count;
`ifdef ALGORITHM_REDUCE_SAT_EN
    assign bus.ovf       = r_ovf;
`else
    assign bus.ovf       = 1'b0;
`endif

endmodule
